// File: rtl/data_sram_ctrl_pkg.sv
// Shared types and constants for the data SRAM bus controller: FSM state
// encoding, access-size codes and the default bus widths.
package data_sram_ctrl_pkg;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/data_sram_ctrl_mem_align.sv
// Pure combinational lane logic: store strobes/replication, misalignment
// detection for the incoming request, and load extract/extend.
module mem_align
    import data_sram_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic        misaligned,
    input  logic [1:0]  ld_size,
    input  logic        ld_sign,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata_raw,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        wstrb      = 4'b1111;
        wdata_lane = wdata;
        misaligned = |off;
        case (size)
            SZ_BYTE: begin
                wstrb      = 4'b0001 << off;
                wdata_lane = {4{wdata[7:0]}};
                misaligned = 1'b0;
            end
            SZ_HALF: begin
                wstrb      = off[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                misaligned = off[0];
            end
            default: begin
                wstrb      = 4'b1111;
                wdata_lane = wdata;
                misaligned = |off;
            end
        endcase
    end

    always_comb begin
        byte_v    = rdata_raw[{ld_off, 3'b000} +: 8];
        half_v    = rdata_raw[{ld_off[1], 4'b0000} +: 16];
        rdata_ext = rdata_raw;
        case (ld_size)
            SZ_BYTE: rdata_ext = {{24{ld_sign & byte_v[7]}}, byte_v};
            SZ_HALF: rdata_ext = {{16{ld_sign & half_v[15]}}, half_v};
            default: rdata_ext = rdata_raw;
        endcase
    end

endmodule

// File: rtl/data_sram_ctrl.sv
// Sequences pipeline loads/stores onto a req/addr_ok/data_ok SRAM bus,
// stalling the pipeline while an access is outstanding.
module data_sram_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_wr,
    input  logic [1:0]    req_size,
    input  logic          req_sign,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic          flush,
    input  logic          mem_allowin,
    output logic          data_sram_req,
    output logic          data_sram_wr,
    output logic [1:0]    data_sram_size,
    output logic [AW-1:0] data_sram_addr,
    output logic [3:0]    data_sram_wstrb,
    output logic [DW-1:0] data_sram_wdata,
    input  logic          data_sram_addr_ok,
    input  logic          data_sram_data_ok,
    input  logic [DW-1:0] data_sram_rdata,
    output logic          stallreq,
    output logic          rdata_valid,
    output logic [DW-1:0] rdata,
    output logic          addr_err
);

    import data_sram_ctrl_pkg::*;

    state_t        state_q, state_d;
    logic          cancel_q, cancel_d;
    logic          bus_load, rd_load, rdata_valid_d, addr_err_d;
    logic          sign_q;
    logic [3:0]    lane_strb;
    logic [31:0]   lane_wdata, load_ext;
    logic          misaligned, accept;

    mem_align u_mem_align (
        .size       (req_size),
        .off        (req_addr[1:0]),
        .wdata      (req_wdata),
        .wstrb      (lane_strb),
        .wdata_lane (lane_wdata),
        .misaligned (misaligned),
        .ld_size    (data_sram_size),
        .ld_sign    (sign_q),
        .ld_off     (data_sram_addr[1:0]),
        .rdata_raw  (data_sram_rdata),
        .rdata_ext  (load_ext)
    );

    assign accept        = req_valid & ~misaligned & ~flush;
    assign data_sram_req = (state_q == ST_REQ);

    always_comb begin
        state_d       = state_q;
        cancel_d      = cancel_q;
        bus_load      = 1'b0;
        rd_load       = 1'b0;
        rdata_valid_d = rdata_valid;
        addr_err_d    = 1'b0;
        stallreq      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                addr_err_d = req_valid & misaligned & ~flush;
                if (accept) begin
                    bus_load = 1'b1;
                    stallreq = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            // Once raised, the request stays up until accepted; a flush only
            // marks the access so its response is dropped.
            ST_REQ: begin
                stallreq = 1'b1;
                if (flush) cancel_d = 1'b1;
                if (data_sram_addr_ok) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                stallreq = 1'b1;
                if (flush) cancel_d = 1'b1;
                if (data_sram_data_ok) begin
                    if (cancel_q | flush) begin
                        state_d = ST_IDLE;
                    end else if (!data_sram_wr) begin
                        rd_load       = 1'b1;
                        rdata_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (mem_allowin | flush) begin
                    rdata_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE) cancel_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_sram_wr    <= 1'b0;
            data_sram_size  <= 2'b00;
            data_sram_addr  <= '0;
            data_sram_wstrb <= 4'b0000;
            data_sram_wdata <= '0;
            sign_q          <= 1'b0;
        end else if (bus_load) begin
            data_sram_wr    <= req_wr;
            data_sram_size  <= req_size;
            data_sram_addr  <= req_addr;
            data_sram_wstrb <= req_wr ? lane_strb : 4'b0000;
            data_sram_wdata <= lane_wdata;
            sign_q          <= req_sign;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_valid <= 1'b0;
            rdata       <= '0;
            addr_err    <= 1'b0;
        end else begin
            rdata_valid <= rdata_valid_d;
            addr_err    <= addr_err_d;
            if (rd_load) rdata <= load_ext;
        end
    end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: loads, stores, misalignment, flush,
// HOLD back-pressure and asynchronous reset, with hand-computed expectations.
module tb_data_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wr, req_sign, flush, mem_allowin;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic        stallreq, rdata_valid, addr_err;
    logic [31:0] rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_sram_ctrl #(.AW(32), .DW(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_wr            (req_wr),
        .req_size          (req_size),
        .req_sign          (req_sign),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .flush             (flush),
        .mem_allowin       (mem_allowin),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .stallreq          (stallreq),
        .rdata_valid       (rdata_valid),
        .rdata             (rdata),
        .addr_err          (addr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one request in IDLE for a single cycle; returns in REQ.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_wr = wr; req_size = sz; req_sign = sg;
        req_addr = a; req_wdata = wd;
        #1 chk1("accept_stall", stallreq, 1'b1);
        cyc();
        req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_sign = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
    endtask

    // Minimum-latency load with MEM advancing immediately.
    task automatic run_load(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                            input logic [31:0] bus, input logic [31:0] exp, input string tag);
        issue(1'b0, sz, sg, a, 32'h0);
        data_sram_addr_ok = 1'b1;
        chk1({tag, "_req"}, data_sram_req, 1'b1);
        chk({tag, "_addr"}, data_sram_addr, a);
        chk({tag, "_wstrb"}, {28'h0, data_sram_wstrb}, 32'h0);
        chk1({tag, "_stall_req"}, stallreq, 1'b1);
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = bus;
        chk1({tag, "_req_drop"}, data_sram_req, 1'b0);
        chk1({tag, "_stall_wait"}, stallreq, 1'b1);
        cyc();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; mem_allowin = 1'b1;
        #1;
        chk1({tag, "_valid"}, rdata_valid, 1'b1);
        chk({tag, "_rdata"}, rdata, exp);
        chk1({tag, "_stall_hold"}, stallreq, 1'b0);
        cyc();
        mem_allowin = 1'b0;
        chk1({tag, "_valid_clr"}, rdata_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_sign = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; flush = 1'b0; mem_allowin = 1'b0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        cyc(); cyc();
        chk1("rst_req", data_sram_req, 1'b0);
        chk1("rst_valid", rdata_valid, 1'b0);
        chk1("rst_addr_err", addr_err, 1'b0);
        chk1("rst_stall", stallreq, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        cyc();

        run_load(2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "ld_word");
        run_load(2'b00, 1'b1, 32'h0000_0103, 32'h8012_3456, 32'hFFFF_FF80, "ld_sbyte");
        run_load(2'b01, 1'b0, 32'h0000_0102, 32'h8012_3456, 32'h0000_8012, "ld_uhalf");
        run_load(2'b01, 1'b1, 32'h0000_0100, 32'h1234_8001, 32'hFFFF_8001, "ld_shalf");
        run_load(2'b00, 1'b0, 32'h0000_0101, 32'h0000_C300, 32'h0000_00C3, "ld_ubyte");

        // Byte store with addr_ok held off for three cycles.
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h1234_56AB);
        for (int i = 0; i < 3; i++) begin
            chk1("st_b_req", data_sram_req, 1'b1);
            chk1("st_b_wr", data_sram_wr, 1'b1);
            chk("st_b_addr", data_sram_addr, 32'h0000_0201);
            chk("st_b_size", {30'h0, data_sram_size}, 32'h0);
            chk("st_b_wstrb", {28'h0, data_sram_wstrb}, 32'h2);
            chk("st_b_wdata", data_sram_wdata, 32'hABAB_ABAB);
            chk1("st_b_stall", stallreq, 1'b1);
            cyc();
        end
        data_sram_addr_ok = 1'b1;
        chk1("st_b_req_last", data_sram_req, 1'b1);
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
        chk1("st_b_req_drop", data_sram_req, 1'b0);
        chk1("st_b_stall_wait", stallreq, 1'b1);
        cyc();
        data_sram_data_ok = 1'b0;
        chk1("st_b_done_stall", stallreq, 1'b0);
        chk1("st_b_no_valid", rdata_valid, 1'b0);

        // Half store in the upper lanes, then a word store.
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'hFFFF_1234);
        data_sram_addr_ok = 1'b1;
        chk("st_h_wstrb", {28'h0, data_sram_wstrb}, 32'hC);
        chk("st_h_wdata", data_sram_wdata, 32'h1234_1234);
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
        cyc();
        data_sram_data_ok = 1'b0;
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0304, 32'h0102_0304);
        data_sram_addr_ok = 1'b1;
        chk("st_w_wstrb", {28'h0, data_sram_wstrb}, 32'hF);
        chk("st_w_wdata", data_sram_wdata, 32'h0102_0304);
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
        cyc();
        data_sram_data_ok = 1'b0;
        chk1("st_w_idle_stall", stallreq, 1'b0);

        // Misaligned word load: one-cycle addr_err, no bus request.
        req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0102;
        #1 chk1("mis_stall", stallreq, 1'b0);
        cyc();
        req_valid = 1'b0; req_size = 2'b00; req_addr = 32'h0;
        chk1("mis_err", addr_err, 1'b1);
        chk1("mis_no_req", data_sram_req, 1'b0);
        cyc();
        chk1("mis_err_clr", addr_err, 1'b0);
        chk1("mis_no_req2", data_sram_req, 1'b0);

        // Flush in IDLE blocks the request and suppresses addr_err.
        req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0101; flush = 1'b1;
        #1 chk1("fl_idle_stall", stallreq, 1'b0);
        cyc();
        req_valid = 1'b0; flush = 1'b0; req_size = 2'b00; req_addr = 32'h0;
        chk1("fl_idle_no_req", data_sram_req, 1'b0);
        chk1("fl_idle_no_err", addr_err, 1'b0);

        // data_ok in IDLE is ignored.
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555;
        cyc();
        data_sram_data_ok = 1'b0;
        chk1("idle_data_ok_ignored", rdata_valid, 1'b0);

        // Flush in WAIT: response consumed and discarded.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0; flush = 1'b1;
        chk1("fl_wait_stall", stallreq, 1'b1);
        cyc();
        flush = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_2222;
        chk1("fl_wait_stall2", stallreq, 1'b1);
        cyc();
        data_sram_data_ok = 1'b0;
        chk1("fl_wait_no_valid", rdata_valid, 1'b0);
        chk1("fl_wait_idle_stall", stallreq, 1'b0);
        chk("fl_wait_rdata_kept", rdata, 32'h0000_00C3);

        // Flush in REQ: request stays up until addr_ok.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0408, 32'h0);
        flush = 1'b1;
        chk1("fl_req_req", data_sram_req, 1'b1);
        cyc();
        flush = 1'b0;
        chk1("fl_req_held", data_sram_req, 1'b1);
        chk("fl_req_addr", data_sram_addr, 32'h0000_0408);
        chk1("fl_req_stall", stallreq, 1'b1);
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h3333_4444;
        chk1("fl_req_req_drop", data_sram_req, 1'b0);
        cyc();
        data_sram_data_ok = 1'b0;
        chk1("fl_req_no_valid", rdata_valid, 1'b0);
        chk1("fl_req_idle_stall", stallreq, 1'b0);

        // HOLD with MEM stalled for four cycles; a stray data_ok is ignored.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_F00D;
        cyc();
        data_sram_rdata = 32'h7777_7777;
        for (int i = 0; i < 4; i++) begin
            data_sram_data_ok = (i == 1);
            #1;
            chk1("hold_valid", rdata_valid, 1'b1);
            chk("hold_rdata", rdata, 32'h0BAD_F00D);
            chk1("hold_stall", stallreq, 1'b0);
            chk1("hold_no_req", data_sram_req, 1'b0);
            cyc();
        end
        data_sram_data_ok = 1'b0; mem_allowin = 1'b1;
        chk1("hold_valid_last", rdata_valid, 1'b1);
        cyc();
        mem_allowin = 1'b0;
        chk1("hold_release", rdata_valid, 1'b0);

        // Asynchronous reset while a store sits in WAIT.
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0600, 32'hCAFE_F00D);
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0;
        chk("pre_rst_wdata", data_sram_wdata, 32'hCAFE_F00D);
        #2 rst = 1'b1;
        #1;
        chk1("arst_stall", stallreq, 1'b0);
        chk1("arst_req", data_sram_req, 1'b0);
        chk1("arst_wr", data_sram_wr, 1'b0);
        chk("arst_size", {30'h0, data_sram_size}, 32'h0);
        chk("arst_addr", data_sram_addr, 32'h0);
        chk("arst_wstrb", {28'h0, data_sram_wstrb}, 32'h0);
        chk("arst_wdata", data_sram_wdata, 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        chk1("arst_valid", rdata_valid, 1'b0);
        chk1("arst_err", addr_err, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();
        run_load(2'b10, 1'b0, 32'h0000_0700, 32'h2468_ACE0, 32'h2468_ACE0, "ld_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
